// File: rtl/id_ex_elastic.sv
// Elastic ID/EX pipeline register: valid/ready handshake over a two-entry skid
// buffer, with flush, load-use hazard stall and a saturating stall counter.
module id_ex_elastic #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_data1,
    input  logic [XLEN-1:0]   id_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_dest_reg,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_memread,
    input  logic              id_regwrite,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_data1,
    output logic [XLEN-1:0]   ex_data2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_dest_reg,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_memread,
    output logic              ex_regwrite,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Entry layout (MSB..LSB): pc, data1, data2, imm, dest_reg, rs1, rs2, rd, memread, regwrite, ctrl
    localparam int EW     = 5 * XLEN + 3 * REG_AW + 2 + CTRL_W;
    localparam int RW_BIT = CTRL_W;
    localparam int MR_BIT = CTRL_W + 1;
    localparam int RD_LSB = CTRL_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ready_q;
    logic              r_ex_valid;
    logic [EW-1:0]     r_out;
    logic [EW-1:0]     r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [EW-1:0]     w_in;
    logic              w_out_hz;
    logic              w_skid_hz;
    logic              w_hazard;
    logic              w_acc;
    logic              w_pop;

    // A held entry blocks decode when it is a load whose result the incoming instruction reads.
    function automatic logic entryHazard(input logic [EW-1:0] e,
                                         input logic [REG_AW-1:0] rs1,
                                         input logic [REG_AW-1:0] rs2);
        logic [REG_AW-1:0] rd;
        rd = e[RD_LSB +: REG_AW];
        return e[MR_BIT] && e[RW_BIT] && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    assign w_in = {id_pc, id_data1, id_data2, id_imm, id_dest_reg,
                   id_rs1, id_rs2, id_rd, id_memread, id_regwrite, id_ctrl};

    assign w_out_hz  = (r_state != S_EMPTY) && entryHazard(r_out, id_rs1, id_rs2);
    assign w_skid_hz = (r_state == S_TWO)   && entryHazard(r_skid, id_rs1, id_rs2);
    assign w_hazard  = id_valid && (w_out_hz || w_skid_hz);

    assign id_ready     = r_ready_q && !w_hazard && !flush;
    assign hazard_stall = w_hazard;
    assign w_acc        = id_valid && id_ready;
    assign w_pop        = r_ex_valid && ex_ready;

    assign ex_valid  = r_ex_valid;
    assign stall_cnt = r_stall_cnt;
    assign {ex_pc, ex_data1, ex_data2, ex_imm, ex_dest_reg,
            ex_rs1, ex_rs2, ex_rd, ex_memread, ex_regwrite, ex_ctrl} = r_out;

    // Occupancy FSM; ready_q and ex_valid are registered alongside the state
    // so ex_ready never reaches id_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_ready_q  <= 1'b1;
            r_ex_valid <= 1'b0;
            r_out      <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_state    <= S_EMPTY;
            r_ready_q  <= 1'b1;
            r_ex_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_out      <= w_in;
                        r_state    <= S_ONE;
                        r_ex_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_pop && w_acc) begin
                        r_out <= w_in;
                    end else if (w_pop) begin
                        r_state    <= S_EMPTY;
                        r_ex_valid <= 1'b0;
                    end else if (w_acc) begin
                        r_skid    <= w_in;
                        r_state   <= S_TWO;
                        r_ready_q <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_out     <= r_skid;
                        r_state   <= S_ONE;
                        r_ready_q <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_ready_q  <= 1'b1;
                    r_ex_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !flush && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

endmodule
